// File: rtl/load_instruction_tx.sv
// load_instruction_tx: streams an 8-word instruction buffer as one burst of strobed beats to a single loader.
// Latency: start accepted in cycle 0, beats in cycles 1..8, gap in cycles 9..10, done_o pulse in cycle 11.
// Backpressure: none from the loader; start while busy is ignored, cfg write while busy is dropped with err_o.
module load_instruction_tx #(
    parameter int NB_PERIPHERALS = 16,
    parameter int LOG_N_INIT     = 4,
    parameter int N_WORDS        = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cfg_we_i,
    input  logic [2:0]                cfg_addr_i,
    input  logic [31:0]               cfg_wdata_i,
    input  logic                      start_i,
    input  logic [LOG_N_INIT-1:0]     target_i,
    input  logic [1:0]                change_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [31:0]               instrut_value_o,
    output logic [NB_PERIPHERALS-1:0] load_ctrl_o,
    output logic [1:0]                change_o
);

    // The receiver commits exactly when its count reaches eight, so the burst length is fixed.
    localparam logic [2:0] LAST_BEAT = 3'(N_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                  state_q;
    logic [2:0]              beat_q;
    logic                    gap_q;
    logic [LOG_N_INIT-1:0]   tgt_q;
    logic [31:0]             buf_q [N_WORDS];

    logic [31:0]             tgt_ext;
    logic                    tgt_ok;
    logic                    start_ok;
    logic                    start_bad;
    logic                    wr_ok;
    logic                    wr_bad;
    logic [2:0]              nxt_beat;
    logic [2:0]              rd_idx;
    logic [31:0]             first_word;

    // One-hot strobe for a target id; callers only pass ids already checked against NB_PERIPHERALS.
    function automatic logic [NB_PERIPHERALS-1:0] onehot(input logic [LOG_N_INIT-1:0] id);
        onehot = NB_PERIPHERALS'(1) << id;
    endfunction

    // Accept/reject decisions for start and cfg writes, plus the read index of the next beat.
    always_comb begin
        tgt_ext   = 32'(target_i);
        tgt_ok    = (tgt_ext < NB_PERIPHERALS);
        start_ok  = start_i && !busy_o && tgt_ok;
        start_bad = start_i && !busy_o && !tgt_ok;
        wr_ok     = cfg_we_i && !busy_o;
        wr_bad    = cfg_we_i && busy_o;
        nxt_beat  = beat_q + 3'd1;
        // The re_ext table only has four entries, so words 0..3 are sent twice.
        rd_idx    = change_o[1] ? {1'b0, nxt_beat[1:0]} : nxt_beat;
        // Beat 0 always reads word 0; a write to it in the start cycle must be forwarded.
        first_word = (wr_ok && (cfg_addr_i == 3'd0)) ? cfg_wdata_i : buf_q[0];
    end

    // Instruction buffer: writable only while no burst is in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_WORDS; i++) begin
                buf_q[i] <= '0;
            end
        end else if (wr_ok) begin
            buf_q[cfg_addr_i] <= cfg_wdata_i;
        end
    end

    // Burst sequencer with registered beat, strobe, busy and done outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ST_IDLE;
            beat_q          <= '0;
            gap_q           <= 1'b0;
            tgt_q           <= '0;
            change_o        <= '0;
            load_ctrl_o     <= '0;
            instrut_value_o <= '0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state_q         <= ST_SEND;
                        beat_q          <= '0;
                        tgt_q           <= target_i;
                        change_o        <= change_i;
                        load_ctrl_o     <= onehot(target_i);
                        instrut_value_o <= first_word;
                        busy_o          <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (beat_q == LAST_BEAT) begin
                        state_q         <= ST_GAP;
                        gap_q           <= 1'b0;
                        load_ctrl_o     <= '0;
                        instrut_value_o <= '0;
                    end else begin
                        beat_q          <= nxt_beat;
                        load_ctrl_o     <= onehot(tgt_q);
                        instrut_value_o <= buf_q[rd_idx];
                    end
                end
                ST_GAP: begin
                    // First gap cycle lets the receiver see count==8, second covers its commit.
                    if (gap_q) begin
                        state_q <= ST_DONE;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                    end else begin
                        gap_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Single error pulse for a rejected start and/or a rejected cfg write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else begin
            err_o <= start_bad || wr_bad;
        end
    end

endmodule
